// File: rtl/data_mem_arbiter_if.sv
// Port bundle for data_mem_arbiter: CPU requester, debug requester and the
// shared data-memory/GPIO port, plus busy and a state view of the sequencer.
interface data_mem_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   // Handshake: a requester raises req with stable we/addr/wdata and holds it
   // until its done pulses for one cycle; rdata is valid only while done=1.
   // Memory side: mem_en strobes for one cycle, mem_rdata is expected
   // MEM_LAT cycles later.
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_done;
   logic          cpu_stall;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_done;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;
   logic [1:0]    arb_state;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_done,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy, arb_state
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_done,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy, arb_state
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory/GPIO port between the CPU memory stage and the
// debug/loader port: one mem_en strobe per access, fixed read latency, done pulse.
module data_mem_arbiter #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int MEM_LAT  = 1,
   parameter int DBG_PRIO = 0
) (
   input logic              clk,
   input logic              rst,
   data_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic       OWN_CPU  = 1'b0;
   localparam logic       OWN_DBG  = 1'b1;
   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   state_t        state;
   logic          owner;
   logic          last_owner;
   logic [3:0]    lat_cnt;
   logic          we_q;

   logic          pick_dbg;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Debug wins when alone, when it has fixed priority, or when the CPU went last.
   assign pick_dbg  = bus.dbg_req &
                      (~bus.cpu_req | (DBG_PRIO != 0) | (last_owner == OWN_CPU));
   assign sel_we    = pick_dbg ? bus.dbg_we    : bus.cpu_we;
   assign sel_addr  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
   assign sel_wdata = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;

   assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
   assign bus.arb_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= OWN_CPU;
         last_owner    <= OWN_DBG;
         lat_cnt       <= '0;
         we_q          <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.cpu_rdata <= '0;
         bus.dbg_rdata <= '0;
         bus.cpu_done  <= 1'b0;
         bus.dbg_done  <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.mem_en   <= 1'b0;
         bus.mem_we   <= 1'b0;
         bus.cpu_done <= 1'b0;
         bus.dbg_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_req || bus.dbg_req) begin
                  owner         <= pick_dbg;
                  last_owner    <= pick_dbg;
                  we_q          <= sel_we;
                  bus.mem_addr  <= sel_addr;
                  bus.mem_wdata <= sel_wdata;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= sel_we;
                  bus.busy      <= 1'b1;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               lat_cnt <= LAT_LOAD;
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == 4'd0) begin
                  // Read data lands in the owner's register together with its done.
                  if (!we_q) begin
                     if (owner == OWN_DBG) bus.dbg_rdata <= bus.mem_rdata;
                     else                  bus.cpu_rdata <= bus.mem_rdata;
                  end
                  if (owner == OWN_DBG) bus.dbg_done <= 1'b1;
                  else                  bus.cpu_done <= 1'b1;
                  state <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single data-memory/GPIO port of the pipelined processor. It shares the port between the CPU memory stage and a debug/loader port. It drives the memory-side strobes for exactly one cycle per transaction and waits a configurable read latency. It returns data with a one-cycle done pulse and holds the CPU pipeline through a stall output until the CPU access completes.

Parameters:
DW, 32, data width of wdata/rdata on all ports
AW, 32, address width on all ports
MEM_LAT, 1, memory cycles from the mem_en cycle to valid mem_rdata; legal 1..15
DBG_PRIO, 0, 0 = round-robin on conflict; 1 = debug always wins on conflict

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request; held high until cpu_done
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data; valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
cpu_stall  out  1  freeze CPU pipeline
dbg_req  in  1  debug request; held high until dbg_done
dbg_we  in  1  debug write
dbg_addr  in  AW  debug address
dbg_wdata  in  DW  debug write data
dbg_rdata  out  DW  read data; valid while dbg_done=1
dbg_done  out  1  one-cycle completion pulse
mem_en  out  1  memory strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, DONE. State register, owner bit, last_owner bit, 4-bit lat_cnt, latched addr/wdata/we and response register are all registered.
- Reset (rst=0, async):
  - State goes to IDLE.
  - mem_en, mem_we, cpu_done, dbg_done and busy are 0 immediately.
  - mem_addr, mem_wdata, cpu_rdata and dbg_rdata are 0.
  - last_owner = DBG, so the CPU wins the first conflict.
  - An in-flight transaction is abandoned; no done pulse is issued.
- IDLE:
  - No request: stay in IDLE.
  - One request: that requester becomes owner.
  - Both requesting with DBG_PRIO=1: DBG is owner.
  - Both requesting with DBG_PRIO=0: owner = opposite of last_owner.
  - On a grant: latch the owner's addr, wdata and we; set last_owner = owner; go to ACCESS.
- ACCESS (exactly 1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values. Load lat_cnt=MEM_LAT-1; go to WAIT.
- WAIT (exactly MEM_LAT cycles):
  - mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their values.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0: capture mem_rdata into the owner's rdata register (reads only; writes leave it unchanged); go to DONE.
- DONE (1 cycle): owner's done=1; rdata valid; go to IDLE.
- Latency: request sampled in IDLE at cycle 0 gives done at cycle MEM_LAT+2. The next grant is possible in the cycle after DONE (IDLE). Peak throughput is one transaction per MEM_LAT+3 cycles.
- A requester still holding req in the IDLE cycle after its done is treated as a new request.
- cpu_stall = cpu_req & ~cpu_done (combinational). It is 0 in the cycle cpu_done pulses and 0 whenever cpu_req=0.
- Request dropped mid-transaction: the transaction still completes and done still pulses; the requester ignores it.
- Requests are only sampled in IDLE. Input changes during ACCESS, WAIT or DONE have no effect on the current transaction.
- The non-owner's done stays 0 and its rdata holds.

Test Plan:
- MEM_LAT=2, CPU read at addr 0x10, memory returns 0xDEADBEEF 2 cycles after mem_en → mem_en high one cycle at cycle 1; cpu_done at cycle 4 with cpu_rdata=0xDEADBEEF; cpu_stall=1 for cycles 0-3, 0 at cycle 4.
- CPU write addr 0x20, data 0x5A → one cycle of mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x5A; cpu_done at MEM_LAT+2; cpu_rdata unchanged.
- DBG_PRIO=0, both requests held continuously, 4 transactions → grant order CPU, DBG, CPU, DBG; each done at the spacing MEM_LAT+3.
- DBG_PRIO=1, both requests held → DBG granted every time; cpu_stall stays 1; CPU is served only after dbg_req drops.
- MEM_LAT=3, rst pulled low during WAIT → outputs zero asynchronously, no done pulse; after release a fresh CPU request completes normally at cycle 5.
- MEM_LAT=1 back-to-back CPU reads 0x1, 0x2 with req held → cpu_done at cycles 3 and 7 with the correct data for each.
